// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings.
package shifter_pkg;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter level: shifts/rotates by 2^K when the current count bit is set, then registers.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int K     = 0,
  localparam int CNTW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  input  logic [CNTW-1:0]  i_cnt,
  input  logic [1:0]       i_op,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNTW-1:0]  o_cnt,
  output logic [1:0]       o_op
);

  localparam int SH = 1 << K;

  logic [WIDTH-1:0] w_shifted;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [CNTW-1:0]  r_cnt;
  logic [1:0]       r_op;

  // Count arrives pre-aligned so bit 0 is this stage's bit.
  always_comb begin
    w_shifted = i_data;
    if (i_cnt[0]) begin
      case (i_op)
        OP_ROL:  w_shifted = (i_data << SH) | (i_data >> (WIDTH - SH));
        OP_SLL:  w_shifted = i_data << SH;
        OP_ROR:  w_shifted = (i_data >> SH) | (i_data << (WIDTH - SH));
        OP_SRL:  w_shifted = i_data >> SH;
        default: w_shifted = i_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_op    <= OP_ROL;
    end else if (i_en) begin
      r_valid <= i_valid;
      r_data  <= w_shifted;
      r_cnt   <= i_cnt >> 1;
      r_op    <= i_op;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;
  assign o_op    = r_op;

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter/rotator: one stage per count bit, whole pipe freezes on output stall.
module shifter_pipe
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int CNTW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNTW-1:0]  in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int STAGES = CNTW;

  logic [STAGES:0]            w_valid;
  logic [STAGES:0][WIDTH-1:0] w_data;
  logic [STAGES:0][CNTW-1:0]  w_cnt;
  logic [STAGES:0][1:0]       w_op;
  logic                       w_stall;
  logic                       w_adv;
  logic                       w_unused_tail;

  assign w_stall  = w_valid[STAGES] && !out_ready;
  assign w_adv    = !w_stall;
  assign in_ready = w_adv;

  // in_valid enters directly: while stalled stage 0 holds, so nothing is taken.
  assign w_valid[0] = in_valid;
  assign w_data[0]  = in_data;
  assign w_cnt[0]   = in_cnt;
  assign w_op[0]    = in_op;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    shift_stage #(
      .WIDTH (WIDTH),
      .K     (k)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_adv),
      .i_valid (w_valid[k]),
      .i_data  (w_data[k]),
      .i_cnt   (w_cnt[k]),
      .i_op    (w_op[k]),
      .o_valid (w_valid[k+1]),
      .o_data  (w_data[k+1]),
      .o_cnt   (w_cnt[k+1]),
      .o_op    (w_op[k+1])
    );
  end

  assign out_valid = w_valid[STAGES];
  assign out_data  = w_data[STAGES];

  assign w_unused_tail = ^{w_cnt[STAGES], w_op[STAGES]};

endmodule

// File: doc/shifter_pipe.md
SHIFTER_PIPE -- requirements
Module: shifter_pipe

Interface
REQ-001 Parameter WIDTH, default 16: data width; SHALL be a power of two, 4..64.
REQ-002 Parameter CNTW, default $clog2(WIDTH): shift-amount width; SHALL be derived, not overridden.
REQ-003 clk  input  1  single clock; all state rising-edge triggered.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operand presented.
REQ-006 in_ready  output  1  block accepts operand this cycle.
REQ-007 in_data  input  WIDTH  operand.
REQ-008 in_cnt  input  CNTW  shift amount, 0..WIDTH-1.
REQ-009 in_op  input  2  00 rotate-left, 01 shift-left-logical, 10 rotate-right, 11 shift-right-logical.
REQ-010 out_valid  output  1  result presented.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 out_data  output  WIDTH  shifted result.

Function
REQ-013 Pipeline SHALL have STAGES = CNTW register stages; stage k shifts/rotates by 2^k when count bit k is 1, else passes data through.
REQ-014 Each stage register SHALL carry valid, data, remaining count bits and op.
REQ-015 Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
REQ-016 Stall = out_valid && !out_ready; in_ready SHALL equal !stall; while stalled every stage register SHALL hold its contents.
REQ-017 When not stalled, all stages SHALL advance together; an empty input slot enters stage 0 as a bubble (valid=0).
REQ-018 Latency SHALL be exactly STAGES cycles from acceptance to out_valid when no stall occurs; throughput one result per cycle.
REQ-019 Logical shifts SHALL fill vacated bits with 0; rotates SHALL wrap bits end-around.
REQ-020 in_cnt = 0 SHALL return in_data unchanged for every op.
REQ-021 Results SHALL leave in acceptance order; none dropped or duplicated under any out_ready pattern.
REQ-022 out_data SHALL be driven from the last stage register, with no combinational path from in_* to out_*.
REQ-023 in_ready SHALL depend combinationally only on out_valid and out_ready.

Reset
REQ-024 rst_n low SHALL asynchronously clear all stage valid bits; out_valid = 0, out_data = 0.
REQ-025 Reset mid-operation SHALL discard all in-flight operands.
REQ-026 in_ready SHALL be 1 during and after reset.
REQ-027 The first operand SHALL be accepted on the first rising edge with rst_n high.

Structure
REQ-028 Package shifter_pkg SHALL hold the op encoding constants (OP_ROL, OP_SLL, OP_ROR, OP_SRL).
REQ-029 Sub-module shift_stage, parameterised by WIDTH and stage index k, SHALL implement one mux level plus its stage register.
REQ-030 shifter_pipe SHALL instantiate STAGES copies of shift_stage via generate and hold the handshake logic.

Verification (WIDTH=16, latency 4)
REQ-031 in_data=0x8001, cnt=1, op=SRL -> out_data=0x4000 exactly 4 cycles later.
REQ-032 in_data=0x1234, cnt=4, op=ROR -> 0x4123; same operand with op=ROL -> 0x2341.
REQ-033 in_data=0xFFFF, cnt=15, op=SLL -> 0x8000; op=SRL -> 0x0001; cnt=0 for all four ops -> 0xFFFF.
REQ-034 Back-to-back stream of 8 operands with out_ready held low 3 cycles mid-stream -> in_ready low exactly while stalled; all 8 results in order, none lost.
REQ-035 rst_n asserted with 3 operands in flight -> out_valid=0 immediately; no stale result appears after release.
REQ-036 Random ops, counts and data with random out_ready, 10k operands -> scoreboard match against a reference shift model.
